keypad_emulator: RTL and testbench

- Synthesizable model of the 4x4 matrix keypad: the passive end of the column-scan/row-sense interface that the keypad scanner drives.
- Accepts "tap key K" commands over a valid/ready handshake and plays out a press: contact bounce, hold for a commanded time, release bounce.
- While the contact is closed, it pulls down the row of key K whenever K's column is driven low.
- Used on-board as a bench stimulus and in simulation as the keypad model for scanner, debouncer and decoder regressions.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_emulator_bounce_lfsr.sv | 30 +++
 rtl/keypad_emulator.sv | 140 ++++++++++++++
 tb/tb_keypad_emulator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad path: FSM states, key positions and the
// hex-key to matrix-position map used by emulator, scanner and decoder.
package keypad_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned LFSR_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HELD,
    ST_RELEASE_BOUNCE
  } state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = E 0 F D
  function automatic key_pos_t key_to_pos(input logic [KEY_W-1:0] key);
    key_pos_t p;
    case (key)
      4'h1:    p = {2'd0, 2'd0};
      4'h2:    p = {2'd0, 2'd1};
      4'h3:    p = {2'd0, 2'd2};
      4'hA:    p = {2'd0, 2'd3};
      4'h4:    p = {2'd1, 2'd0};
      4'h5:    p = {2'd1, 2'd1};
      4'h6:    p = {2'd1, 2'd2};
      4'hB:    p = {2'd1, 2'd3};
      4'h7:    p = {2'd2, 2'd0};
      4'h8:    p = {2'd2, 2'd1};
      4'h9:    p = {2'd2, 2'd2};
      4'hC:    p = {2'd2, 2'd3};
      4'hE:    p = {2'd3, 2'd0};
      4'h0:    p = {2'd3, 2'd1};
      4'hF:    p = {2'd3, 2'd2};
      default: p = {2'd3, 2'd3};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for contact bounce. next_bit_c is
// bit 0 of the value the register will hold after the coming edge.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic next_bit_c
);

  logic [LFSR_W-1:0] q;
  logic              fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

  // Lookahead lets the registered contact output track the LFSR cycle-for-cycle
  assign next_bit_c = en ? fb : q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: plays a tapped key as press bounce, hold and
// release bounce, pulling the key's row low while its column is driven.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned         BOUNCE_CYCLES = 16,
  parameter logic [LFSR_W-1:0]   LFSR_SEED     = 8'hA5,
  parameter int unsigned         HOLD_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col_n,
  output logic [NUM_ROWS-1:0] row_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [KEY_W-1:0]    cmd_key,
  input  logic [HOLD_W-1:0]   cmd_hold,
  output logic                contact,
  output logic                busy,
  output logic                done
);

  localparam bit          HAS_BOUNCE = (BOUNCE_CYCLES != 0);
  localparam int unsigned BCNT_W     = HAS_BOUNCE ? $clog2(BOUNCE_CYCLES + 1) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST =
    BCNT_W'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);

  state_e              state, state_n;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;
  logic [HOLD_W-1:0]   hcnt, hcnt_n;
  logic [HOLD_W-1:0]   hold_last, hold_last_n;
  key_pos_t            pos, pos_n;
  logic                contact_n;
  logic                done_n;
  logic                lfsr_en_c;
  logic                lfsr_bit_c;
  logic [NUM_ROWS-1:0] row_n_n;

  assign lfsr_en_c = (state == ST_PRESS_BOUNCE) || (state == ST_RELEASE_BOUNCE);

  bounce_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .en        (lfsr_en_c),
    .next_bit_c(lfsr_bit_c)
  );

  // Next-state, counters, and the contact value of the cycle being entered
  always_comb begin
    state_n     = state;
    bcnt_n      = bcnt;
    hcnt_n      = hcnt;
    hold_last_n = hold_last;
    pos_n       = pos;
    contact_n   = 1'b0;
    done_n      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pos_n       = key_to_pos(cmd_key);
          hold_last_n = (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);
          bcnt_n      = '0;
          hcnt_n      = '0;
          state_n     = HAS_BOUNCE ? ST_PRESS_BOUNCE : ST_HELD;
        end
      end
      ST_PRESS_BOUNCE: begin
        if (bcnt == BCNT_LAST) begin
          hcnt_n  = '0;
          state_n = ST_HELD;
        end else begin
          bcnt_n = bcnt + BCNT_W'(1);
        end
      end
      ST_HELD: begin
        if (hcnt == hold_last) begin
          bcnt_n  = '0;
          state_n = HAS_BOUNCE ? ST_RELEASE_BOUNCE : ST_IDLE;
        end else begin
          hcnt_n = hcnt + HOLD_W'(1);
        end
      end
      ST_RELEASE_BOUNCE: begin
        if (bcnt == BCNT_LAST) begin
          state_n = ST_IDLE;
        end else begin
          bcnt_n = bcnt + BCNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    case (state_n)
      ST_PRESS_BOUNCE:   contact_n = (bcnt_n == BCNT_LAST) ? 1'b1 : lfsr_bit_c;
      ST_HELD:           contact_n = 1'b1;
      ST_RELEASE_BOUNCE: contact_n = (bcnt_n == BCNT_LAST) ? 1'b0 : lfsr_bit_c;
      default:           contact_n = 1'b0;
    endcase

    done_n = (state != ST_IDLE) && (state_n == ST_IDLE);
  end

  // Only the latched key's row responds, and only to its own column
  always_comb begin
    row_n_n = '1;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      row_n_n[r] = !(contact && !col_n[pos.col] && (pos.row == 2'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bcnt      <= '0;
      hcnt      <= '0;
      hold_last <= '0;
      pos       <= '0;
      contact   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      row_n     <= '1;
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      hcnt      <= hcnt_n;
      hold_last <= hold_last_n;
      pos       <= pos_n;
      contact   <= contact_n;
      busy      <= (state_n != ST_IDLE);
      done      <= done_n;
      cmd_ready <= (state_n == ST_IDLE);
      row_n     <= row_n_n;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a bounce-enabled and a bounce-free instance, each
// checked every cycle against a tap-trace model plus directed literal checks.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic        cmd_valid_i [2];
  logic [3:0]  cmd_key_i   [2];
  logic [15:0] cmd_hold_i  [2];
  logic [3:0]  row_n_o     [2];
  logic        cmd_ready_o [2];
  logic        contact_o   [2];
  logic        busy_o      [2];
  logic        done_o      [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(16), .LFSR_SEED(8'hA5), .HOLD_W(16)) u_dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n_o[0]),
    .cmd_valid(cmd_valid_i[0]), .cmd_ready(cmd_ready_o[0]),
    .cmd_key(cmd_key_i[0]), .cmd_hold(cmd_hold_i[0]),
    .contact(contact_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  keypad_emulator #(.BOUNCE_CYCLES(0), .LFSR_SEED(8'hA5), .HOLD_W(16)) u_dut_nb (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n_o[1]),
    .cmd_valid(cmd_valid_i[1]), .cmd_ready(cmd_ready_o[1]),
    .cmd_key(cmd_key_i[1]), .cmd_hold(cmd_hold_i[1]),
    .contact(contact_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h, want %0h", name, d, act, exp);
    end
  endtask

  // ---------------- model: each accepted tap becomes a contact trace ----------------
  logic [3:0] layout [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};
  bit         trace [2][256];
  int         tlen [2];
  int         tpos [2];
  int         krow [2];
  int         kcol [2];
  logic [7:0] mlfsr [2];
  logic       exp_contact [2];
  logic       exp_busy [2];
  logic       exp_done [2];
  logic       exp_ready [2];
  logic [3:0] exp_row [2];
  bit         chk_en = 1'b0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic int bounce_len(input int d);
    return (d == 0) ? 16 : 0;
  endfunction

  task automatic build_trace(input int d);
    int n = 0;
    int h = (cmd_hold_i[d] == 16'd0) ? 1 : int'(cmd_hold_i[d]);
    int b = bounce_len(d);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == cmd_key_i[d]) begin krow[d] = r; kcol[d] = c; end
    for (int i = 0; i < b; i++) begin
      trace[d][n] = (i == b - 1) ? 1'b1 : mlfsr[d][0];
      mlfsr[d] = lfsr_step(mlfsr[d]);
      n++;
    end
    for (int i = 0; i < h && n < 240; i++) begin trace[d][n] = 1'b1; n++; end
    for (int i = 0; i < b; i++) begin
      trace[d][n] = (i == b - 1) ? 1'b0 : mlfsr[d][0];
      mlfsr[d] = lfsr_step(mlfsr[d]);
      n++;
    end
    tlen[d] = n;
  endtask

  task automatic model_step(input int d);
    exp_row[d] = (!rst && exp_contact[d] && !col_n[kcol[d]]) ?
                 4'(~(4'b0001 << krow[d])) : 4'hF;
    if (rst) begin
      tlen[d] = 0; tpos[d] = 0; mlfsr[d] = 8'hA5;
      exp_contact[d] = 1'b0; exp_busy[d] = 1'b0; exp_done[d] = 1'b0; exp_ready[d] = 1'b1;
    end else if (exp_ready[d]) begin
      exp_done[d] = 1'b0;
      exp_contact[d] = 1'b0;
      if (cmd_valid_i[d]) begin
        build_trace(d);
        tpos[d] = 0;
        exp_contact[d] = trace[d][0];
        exp_busy[d] = 1'b1;
        exp_ready[d] = 1'b0;
      end
    end else begin
      tpos[d]++;
      if (tpos[d] >= tlen[d]) begin
        exp_contact[d] = 1'b0; exp_busy[d] = 1'b0; exp_ready[d] = 1'b1; exp_done[d] = 1'b1;
      end else begin
        exp_contact[d] = trace[d][tpos[d]];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    if (rst) chk_en = 1'b1;
  end

  // Cycle compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check("row_n",     d, 32'(row_n_o[d]),     32'(exp_row[d]));
        check("contact",   d, 32'(contact_o[d]),   32'(exp_contact[d]));
        check("busy",      d, 32'(busy_o[d]),      32'(exp_busy[d]));
        check("done",      d, 32'(done_o[d]),      32'(exp_done[d]));
        check("cmd_ready", d, 32'(cmd_ready_o[d]), 32'(exp_ready[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tap(input int d, input logic [3:0] key, input logic [15:0] hold,
                         input int ncyc, output logic [63:0] cs, output int nbusy,
                         output int nrow, output int ndone, output int done_at,
                         output int first_busy);
    cs = '0; nbusy = 0; nrow = 0; ndone = 0; done_at = -1; first_busy = -1;
    cmd_key_i[d] = key; cmd_hold_i[d] = hold; cmd_valid_i[d] = 1'b1;
    for (int t = 0; t < ncyc; t++) begin
      if (t == 1) cmd_valid_i[d] = 1'b0;
      if (t < 64) cs[t] = contact_o[d];
      if (busy_o[d]) begin
        nbusy++;
        if (first_busy < 0) first_busy = t;
      end
      if (row_n_o[d] != 4'hF) nrow++;
      if (done_o[d]) begin ndone++; done_at = t; end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] cs;
    int nbusy, nrow, ndone, done_at, first_busy, g, nr3, nstray;

    rst = 1'b1; col_n = 4'hF;
    for (int d = 0; d < 2; d++) begin
      cmd_valid_i[d] = 1'b0; cmd_key_i[d] = 4'h0; cmd_hold_i[d] = 16'd0;
    end

    check("model lfsr step1", 0, 32'(lfsr_step(8'hA5)), 32'h4A);
    check("model lfsr step2", 0, 32'(lfsr_step(8'h4A)), 32'h95);

    // 1: reset
    tick(); tick();
    rst = 1'b0; col_n = 4'h0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check("t1 row_n",     d, 32'(row_n_o[d]), 32'hF);
      check("t1 cmd_ready", d, 32'(cmd_ready_o[d]), 32'd1);
      check("t1 busy",      d, 32'(busy_o[d]), 32'd0);
      check("t1 done",      d, 32'(done_o[d]), 32'd0);
      check("t1 contact",   d, 32'(contact_o[d]), 32'd0);
    end

    // 2: no-bounce tap of key 5
    col_n = 4'b1101;
    run_tap(1, 4'h5, 16'd10, 30, cs, nbusy, nrow, ndone, done_at, first_busy);
    check("t2 first busy cycle", 1, 32'(first_busy), 32'd1);
    check("t2 busy cycles",      1, 32'(nbusy), 32'd10);
    check("t2 row low cycles",   1, 32'(nrow), 32'd10);
    check("t2 done count",       1, 32'(ndone), 32'd1);
    check("t2 done cycle",       1, 32'(done_at), 32'd11);

    // 3: key D under a rotating one-cold column scan
    nr3 = 0; nstray = 0;
    cmd_key_i[1] = 4'hD; cmd_hold_i[1] = 16'd40;
    for (int t = 0; t < 50; t++) begin
      col_n = 4'(~(4'b0001 << ((t / 4) % 4)));
      cmd_valid_i[1] = (t == 0);
      if (!row_n_o[1][3]) nr3++;
      if (row_n_o[1][2:0] != 3'b111) nstray++;
      tick();
    end
    cmd_valid_i[1] = 1'b0;
    check("t3 row3 low cycles", 1, 32'(nr3), 32'd8);
    check("t3 rows0-2 low",     1, 32'(nstray), 32'd0);

    // 4: bounce determinism, key 0 hold 5
    col_n = 4'b1101;
    run_tap(0, 4'h0, 16'd5, 45, cs, nbusy, nrow, ndone, done_at, first_busy);
    check("t4 press bounce 1..6", 0, 32'(cs[6:1]), 32'b100101);
    check("t4 press last",        0, 32'(cs[16]), 32'd1);
    check("t4 release last",      0, 32'(cs[37]), 32'd0);
    check("t4 busy cycles",       0, 32'(nbusy), 32'd37);
    check("t4 done cycle",        0, 32'(done_at), 32'd38);

    // 5: back-to-back handshake, input changes mid-tap ignored
    col_n = 4'b0100;
    cmd_key_i[0] = 4'h1; cmd_hold_i[0] = 16'd3; cmd_valid_i[0] = 1'b1;
    tick();
    check("t5 accept1 busy", 0, 32'(busy_o[0]), 32'd1);
    cmd_key_i[0] = 4'hA;
    g = 0;
    while (!done_o[0] && g < 100) begin tick(); g++; end
    check("t5 tap1 length",       0, 32'(g), 32'd35);
    check("t5 done1 seen",        0, 32'(done_o[0]), 32'd1);
    check("t5 ready in done cyc", 0, 32'(cmd_ready_o[0]), 32'd1);
    tick();
    check("t5 accept2 in done cyc", 0, 32'(busy_o[0]), 32'd1);
    cmd_valid_i[0] = 1'b0; cmd_key_i[0] = 4'h5; cmd_hold_i[0] = 16'd100;
    nbusy = 1; g = 0;
    while (!done_o[0] && g < 200) begin
      tick(); g++;
      if (busy_o[0]) nbusy++;
    end
    check("t5 tap2 busy cycles", 0, 32'(nbusy), 32'd35);
    check("t5 done2 seen",       0, 32'(done_o[0]), 32'd1);

    // 6: reset during HELD
    col_n = 4'b1101;
    cmd_key_i[0] = 4'h0; cmd_hold_i[0] = 16'd20; cmd_valid_i[0] = 1'b1;
    tick();
    cmd_valid_i[0] = 1'b0;
    repeat (19) tick();
    check("t6 row low in HELD", 0, 32'(row_n_o[0]), 32'h7);
    rst = 1'b1;
    tick();
    check("t6 row_n at reset", 0, 32'(row_n_o[0]), 32'hF);
    check("t6 busy at reset",  0, 32'(busy_o[0]), 32'd0);
    check("t6 done at reset",  0, 32'(done_o[0]), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int t = 0; t < 40; t++) begin
      if (done_o[0]) ndone++;
      tick();
    end
    check("t6 no done after abort", 0, 32'(ndone), 32'd0);
    run_tap(0, 4'h0, 16'd5, 45, cs, nbusy, nrow, ndone, done_at, first_busy);
    check("t6 lfsr restart 1..6", 0, 32'(cs[6:1]), 32'b100101);
    check("t6 busy cycles",       0, 32'(nbusy), 32'd37);
    check("t6 done count",        0, 32'(ndone), 32'd1);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
